// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// STEP_BITS result bits per cycle. Define MULDIV_EARLY_OUT_EN to finish trivial cases in one cycle.
module execute_muldiv #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [6:0]      decode_opcode,
    input  logic [2:0]      decode_funct3,
    input  logic [6:0]      decode_funct7,
    input  logic [XLEN-1:0] read_rs1_val,
    input  logic [XLEN-1:0] read_rs2_val,
    input  logic            read_valid,
    output logic            read_stall,
    output logic            processing,
    output logic            valid,
    input  logic            stall,
    output logic [XLEN-1:0] rd_val_out
);
    localparam int N  = XLEN / STEP_BITS;
    localparam int CW = $clog2(N) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              claim_s, is_div_s, a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic              div_zero_s, div_ovf_s, early_s, special_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s, special_res_s;
    logic [XLEN+STEP_BITS-1:0]   mul_hi_s;
    logic [2*XLEN+STEP_BITS-1:0] mul_cat_s;
    logic [XLEN:0]     div_trial_s;
    logic [XLEN-1:0]   div_rem_s, div_quo_s;
    logic [2*XLEN-1:0] step_s, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_s;

    // Claim decode, operand magnitudes and single-cycle special cases.
    always_comb begin
        claim_s = read_valid && !flush && (decode_opcode == 7'b0110011) &&
                  (decode_funct7 == 7'b0000001) &&
                  ((state_q == IDLE) || ((state_q == DONE) && !stall));
        is_div_s = decode_funct3[2];
        if (is_div_s) begin
            a_sgn_s = ~decode_funct3[0];
            b_sgn_s = ~decode_funct3[0];
        end else begin
            a_sgn_s = (decode_funct3[1:0] == 2'b01) || (decode_funct3[1:0] == 2'b10);
            b_sgn_s = (decode_funct3[1:0] == 2'b01);
        end
        a_neg_s = a_sgn_s & read_rs1_val[XLEN-1];
        b_neg_s = b_sgn_s & read_rs2_val[XLEN-1];
        a_mag_s = a_neg_s ? -read_rs1_val : read_rs1_val;
        b_mag_s = b_neg_s ? -read_rs2_val : read_rs2_val;
        div_zero_s = is_div_s && (read_rs2_val == {XLEN{1'b0}});
        div_ovf_s  = is_div_s && !decode_funct3[0] && (read_rs1_val == MOST_NEG) &&
                     (read_rs2_val == ALL_ONES);
`ifdef MULDIV_EARLY_OUT_EN
        early_s = is_div_s ? (a_mag_s < b_mag_s)
                           : ((read_rs1_val == {XLEN{1'b0}}) || (read_rs2_val == {XLEN{1'b0}}));
`else
        early_s = 1'b0;
`endif
        special_s = div_zero_s || div_ovf_s || early_s;
        if (div_zero_s) begin
            special_res_s = decode_funct3[1] ? read_rs1_val : ALL_ONES;
        end else if (div_ovf_s) begin
            special_res_s = decode_funct3[1] ? {XLEN{1'b0}} : MOST_NEG;
        end else if (early_s && is_div_s && decode_funct3[1]) begin
            special_res_s = read_rs1_val;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_hi_s  = {{STEP_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
                    ({{STEP_BITS{1'b0}}, b_q} * {{XLEN{1'b0}}, acc_q[STEP_BITS-1:0]});
        mul_cat_s = {mul_hi_s, acc_q[XLEN-1:0]};
        div_rem_s = acc_q[2*XLEN-1:XLEN];
        div_quo_s = acc_q[XLEN-1:0];
        div_trial_s = {(XLEN+1){1'b0}};
        for (int k = 0; k < STEP_BITS; k++) begin
            div_trial_s = {div_rem_s, div_quo_s[XLEN-1]};
            div_quo_s   = {div_quo_s[XLEN-2:0], 1'b0};
            if (div_trial_s >= {1'b0, b_q}) begin
                div_trial_s  = div_trial_s - {1'b0, b_q};
                div_quo_s[0] = 1'b1;
            end else begin
                div_quo_s[0] = 1'b0;
            end
            div_rem_s = div_trial_s[XLEN-1:0];
        end
        step_s  = op_q[2] ? {div_rem_s, div_quo_s} : mul_cat_s[2*XLEN+STEP_BITS-1:STEP_BITS];
        prod_s  = neg_quo_q ? -step_s : step_s;
        quo_s   = neg_quo_q ? -step_s[XLEN-1:0] : step_s[XLEN-1:0];
        rem_s   = neg_rem_q ? -step_s[2*XLEN-1:XLEN] : step_s[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_s = op_q[1] ? rem_s : quo_s;
        end else begin
            final_s = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state: flush beats a claim, a claim beats the current state's own progress.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (flush) begin
            state_d  = IDLE;
            result_d = {XLEN{1'b0}};
        end else if (claim_s) begin
            op_d      = decode_funct3;
            neg_quo_d = a_neg_s ^ b_neg_s;
            neg_rem_d = a_neg_s;
            b_d       = b_mag_s;
            acc_d     = {{XLEN{1'b0}}, a_mag_s};
            cnt_d     = CW'(N - 1);
            if (special_s) begin
                state_d  = DONE;
                result_d = special_res_s;
            end else begin
                state_d  = ITER;
                result_d = {XLEN{1'b0}};
            end
        end else begin
            case (state_q)
                ITER: begin
                    acc_d = step_s;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d  = DONE;
                        result_d = final_s;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (!stall) begin
                        state_d  = IDLE;
                        result_d = {XLEN{1'b0}};
                    end else begin
                        state_d = DONE;
                    end
                end
                IDLE: state_d = IDLE;
                default: begin
                    state_d  = IDLE;
                    result_d = {XLEN{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            b_q       <= {XLEN{1'b0}};
            op_q      <= 3'b000;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {XLEN{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign valid      = (state_q == DONE);
    assign rd_val_out = result_q;
    assign read_stall = (state_q != IDLE) && !((state_q == DONE) && !stall);
    assign processing = claim_s || (state_q != IDLE);
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: a STEP_BITS=1 and a STEP_BITS=4 instance share operands.
module tb_execute_muldiv;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    typedef struct {
        logic [31:0] val;
        int          due;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, rv1, rv4, stall;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, rd1, rd4;
    logic        read_stall1, processing1, valid1;
    logic        read_stall4, processing4, valid4;
    logic        flush4 = 1'b0;
    logic        stall4 = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q1[$];
    exp_t        q4[$];

    execute_muldiv #(.XLEN(32), .STEP_BITS(1)) u_dut1 (
        .clk(clk), .reset(reset), .flush(flush), .decode_opcode(opcode),
        .decode_funct3(funct3), .decode_funct7(funct7), .read_rs1_val(rs1),
        .read_rs2_val(rs2), .read_valid(rv1), .read_stall(read_stall1),
        .processing(processing1), .valid(valid1), .stall(stall), .rd_val_out(rd1));

    execute_muldiv #(.XLEN(32), .STEP_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .flush(flush4), .decode_opcode(opcode),
        .decode_funct3(funct3), .decode_funct7(funct7), .read_rs1_val(rs1),
        .read_rs2_val(rs2), .read_valid(rv4), .read_stall(read_stall4),
        .processing(processing4), .valid(valid4), .stall(stall4), .rd_val_out(rd4));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor for the STEP_BITS=1 unit; also checks the result holds while stalled.
    task automatic mon1();
        logic        seen;
        logic [31:0] held;
        exp_t        e;
        seen = 1'b0;
        held = 32'h0;
        forever begin
            @(negedge clk);
            if (valid1) begin
                if (!seen) begin
                    if (q1.size() == 0) begin
                        chk("unexpected_valid1", 32'd1, 32'd0);
                    end else begin
                        e = q1.pop_front();
                        chk(e.name, rd1, e.val);
                        chk({e.name, "_latency"}, cyc, e.due);
                    end
                    seen = 1'b1;
                    held = rd1;
                end else begin
                    chk("stall_hold_value", rd1, held);
                end
                if (!stall) seen = 1'b0;
            end else begin
                seen = 1'b0;
            end
        end
    endtask

    task automatic mon4();
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid4) begin
                if (q4.size() == 0) begin
                    chk("unexpected_valid4", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk(e.name, rd4, e.val);
                    chk({e.name, "_latency"}, cyc, e.due);
                end
            end
        end
    endtask

    // Called #1 after a posedge; strobes one claim and optionally records the expectation.
    task automatic issue(input bit d4, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_it, input logic [31:0] ev,
                         input int lat, input string nm);
        exp_t e;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        if (d4) rv4 = 1'b1;
        else    rv1 = 1'b1;
        e.val  = ev;
        e.due  = cyc + lat;
        e.name = nm;
        if (expect_it) begin
            if (d4) q4.push_back(e);
            else    q1.push_back(e);
        end
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        rv4 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (((q1.size() + q4.size()) != 0) && (n < 200)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", q1.size() + q4.size(), 32'd0);
    endtask

    task automatic run(input bit d4, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ev, input int lat,
                       input string nm);
        issue(d4, f3, a, b, 1'b1, ev, lat, nm);
        drain();
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        flush  = 1'b0;
        rv1    = 1'b0;
        rv4    = 1'b0;
        stall  = 1'b0;
        opcode = 7'b0110011;
        funct7 = 7'b0000001;
        funct3 = 3'b000;
        rs1    = 32'h0;
        rs2    = 32'h0;
        fork
            mon1();
            mon4();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, valid1}, 32'd0);
        chk("reset_processing", {31'd0, processing1}, 32'd0);
        chk("reset_read_stall", {31'd0, read_stall1}, 32'd0);
        chk("reset_rd_val", rd1, 32'h0);
        chk("reset_valid4", {31'd0, valid4}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFEB, 33, "mul_7_neg3");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid1) break;
            if (read_stall1) n++;
        end
        chk("read_stall_iter_cycles", n, 32'd32);
        drain();

        run(1'b0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_minmin");
        run(1'b0, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu");
        run(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
        run(1'b0, 3'b000, 32'h12345678, 32'd9, 32'hA3D70A38, 33, "mul_low");
        run(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_overflow");
        run(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, "rem_overflow");
        run(1'b0, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_by_zero");
        run(1'b0, 3'b110, 32'd7, 32'd0, 32'd7, 1, "rem_by_zero");
        run(1'b0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_neg7_2");
        run(1'b0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_neg7_2");
        run(1'b0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");

        // Wrong funct7 must not be claimed.
        funct7 = 7'b0000000;
        rv1 = 1'b1;
        #1;
        chk("noclaim_processing", {31'd0, processing1}, 32'd0);
        @(posedge clk);
        #1;
        rv1 = 1'b0;
        funct7 = 7'b0000001;
        chk("noclaim_idle", {31'd0, processing1}, 32'd0);
        chk("noclaim_read_stall", {31'd0, read_stall1}, 32'd0);

        // Hold under stall, then release together with a new claim.
        stall = 1'b1;
        issue(1'b0, 3'b111, 32'd100, 32'd7, 1'b1, 32'd2, 33, "remu_stalled");
        n = 0;
        while (!valid1 && (n < 50)) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", {31'd0, valid1}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_valid_held", {31'd0, valid1}, 32'd1);
            chk("stall_read_stall", {31'd0, read_stall1}, 32'd1);
        end
        stall = 1'b0;
        issue(1'b0, 3'b000, 32'd6, 32'd7, 1'b1, 32'd42, 33, "mul_back_to_back");
        chk("b2b_valid_drop", {31'd0, valid1}, 32'd0);
        chk("b2b_processing", {31'd0, processing1}, 32'd1);
        drain();

        // Flush in the fifth ITER cycle discards the divide.
        issue(1'b0, 3'b101, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "divu_flushed");
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_valid", {31'd0, valid1}, 32'd0);
        chk("flush_processing", {31'd0, processing1}, 32'd0);
        chk("flush_read_stall", {31'd0, read_stall1}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        run(1'b0, 3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");

        run(1'b0, 3'b000, 32'd0, 32'd9, 32'd0, EO_LAT, "mul_zero");
        run(1'b0, 3'b101, 32'd3, 32'd7, 32'd0, EO_LAT, "divu_small");

        run(1'b1, 3'b101, 32'd100, 32'd7, 32'd14, 9, "divu_step4");
        run(1'b1, 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 9, "mulhu_step4");
        run(1'b1, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 9, "rem_step4");

        // Reset in the middle of an operation aborts it.
        issue(1'b1, 3'b101, 32'd100, 32'd7, 1'b0, 32'd0, 0, "divu_reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_valid4", {31'd0, valid4}, 32'd0);
        chk("midreset_processing4", {31'd0, processing4}, 32'd0);
        chk("midreset_read_stall4", {31'd0, read_stall4}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        run(1'b1, 3'b000, 32'd3, 32'd4, 32'd12, 9, "mul_step4_after_reset");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
